grant_bus_mux: RTL and testbench
================================

GRANT_BUS_MUX -- requirements
Module: grant_bus_mux

Interface
REQ-001 Parameter TIMEOUT, default 64, range 2-255: idle cycles allowed in XFER with no accepted beat before error.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 gnt3..gnt0  input  1 each  grants from the upstream 4-way round-robin arbiter; expected one-hot or zero.
REQ-005 len3..len0  input  4 each  per-client burst length minus one (1-16 beats); sampled at grant capture.
REQ-006 dat3..dat0  input  8 each  per-client data beat.
REQ-007 vld3..vld0  input  1 each  per-client beat valid.
REQ-008 rdy3..rdy0  output  1 each  per-client beat accepted.
REQ-009 bus_dat  output  8  shared bus data.
REQ-010 bus_vld  output  1  shared bus beat valid.
REQ-011 bus_ready  input  1  downstream sink ready.
REQ-012 bus_last  output  1  current beat is the final beat of the burst.
REQ-013 bus_owner  output  2  encoded index of the latched owner.
REQ-014 done3..done0  output  1 each  one-cycle burst-complete pulse per client.
REQ-015 abort  output  1  one-cycle pulse when the owner's grant drops mid-burst.
REQ-016 err  output  1  sticky error flag.
REQ-017 err_clr  input  1  clears err and leaves ERR.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, XFER, DONE, ERR.
- IDLE, exactly one gnt high and not held off (REQ-026): latch owner index into bus_owner, load beat counter with that client's len, clear timeout counter, go XFER next cycle.
- IDLE, more than one gnt high: go ERR.
REQ-020 In XFER: bus_dat = dat[owner], bus_vld = vld[owner], rdy[owner] = bus_ready, combinationally; all other rdy = 0.
REQ-021 Beat accepted when bus_vld & bus_ready; each accepted beat decrements the beat counter and clears the timeout counter.
REQ-022 bus_last = 1 in XFER when beat counter = 0; accepted beat with bus_last = 1 -> DONE.
REQ-023 In XFER, timeout counter increments on each cycle without an accepted beat; reaching TIMEOUT-1 with no beat accepted -> ERR.
REQ-024 In XFER, gnt[owner] low (checked before beat acceptance) -> abort = 1 for one cycle, no beat accepted that cycle, go IDLE.
REQ-025 DONE lasts one cycle: done[owner] = 1, bus_vld = 0, then IDLE.
REQ-026 Holdoff: on the first IDLE cycle after DONE or abort, a grant for the previous owner is ignored (arbiter grant release lag); grants for other clients are accepted.
REQ-027 In ERR: err = 1, bus_vld = 0, all rdy = 0; err_clr = 1 -> IDLE next cycle with err = 0.
REQ-028 err_clr outside ERR has no effect.
REQ-029 Outside XFER, bus_vld, bus_last and all rdy = 0; bus_dat = 0.
REQ-030 Beat counter is 4 bits and never wraps; timeout counter is 8 bits and saturates at TIMEOUT-1.
REQ-031 Simultaneous last-beat acceptance and timeout: beat acceptance wins (-> DONE).

Reset
REQ-032 rst high, asynchronously: state IDLE, bus_owner = 0, counters = 0, holdoff cleared, err = 0, busy = 0, abort = 0, all done = 0.
REQ-033 rst mid-burst abandons the burst with no done or abort pulse; operation resumes from IDLE on the first clk edge after rst falls.

Verification
REQ-034 gnt1 = 1, len1 = 3, vld1 = 1, bus_ready = 1 -> 4 beats of dat1 on bus; bus_last on the 4th beat; done1 pulse; bus_owner = 1.
REQ-035 bus_ready low for 3 cycles mid-burst, TIMEOUT = 64 -> no beats accepted, burst completes afterwards, err = 0.
REQ-036 vld2 = 0 for 64 cycles in XFER, TIMEOUT = 64 -> err = 1; err_clr pulse -> IDLE, err = 0.
REQ-037 gnt0 drops after 2 of 8 beats -> abort pulse, no done0; holdoff ignores gnt0 on the next cycle; a gnt3 on that same cycle is accepted.
REQ-038 gnt1 and gnt2 both high in IDLE -> ERR; rst asserted during an XFER burst -> all outputs at reset values immediately, no done pulse.

Source files
------------

// File: rtl/grant_bus_mux_if.sv
// Grant bus mux bundle: four client lanes, shared bus, status.
// master = mux side, slave = clients/sink/controller side.
interface grant_bus_mux_if;
  logic [3:0]      gnt;
  logic [3:0][3:0] len;
  logic [3:0][7:0] dat;
  logic [3:0]      vld;
  logic [3:0]      rdy;
  logic [7:0]      bus_dat;
  logic            bus_vld;
  logic            bus_ready;
  logic            bus_last;
  logic [1:0]      bus_owner;
  logic [3:0]      done;
  logic            abort;
  logic            err;
  logic            err_clr;
  logic            busy;

  modport master (
    input  gnt, len, dat, vld, bus_ready, err_clr,
    output rdy, bus_dat, bus_vld, bus_last, bus_owner,
    output done, abort, err, busy
  );

  modport slave (
    output gnt, len, dat, vld, bus_ready, err_clr,
    input  rdy, bus_dat, bus_vld, bus_last, bus_owner,
    input  done, abort, err, busy
  );
endinterface

// File: rtl/grant_bus_mux.sv
// Muxes one of four granted clients onto a shared burst bus.
// Ports: clk, rst (async high), m = grant_bus_mux_if.master.
module grant_bus_mux #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  grant_bus_mux_if.master  m
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic       hold_q, hold_d;

  logic [3:0] own_oh;
  logic [3:0] eff_gnt;
  logic       multi_gnt;
  logic [1:0] gnt_idx;
  logic       own_gnt;
  logic       own_vld;
  logic [7:0] own_dat;
  logic       beat_ok;

  logic [3:0] rdy_o;
  logic [7:0] bus_dat_o;
  logic       bus_vld_o;
  logic       bus_last_o;
  logic [3:0] done_o;
  logic       abort_o;

  assign own_oh  = 4'b0001 << owner_q;
  // Previous owner's grant may linger one cycle after release.
  assign eff_gnt = m.gnt & ~(hold_q ? own_oh : 4'b0000);
  assign multi_gnt = (eff_gnt & (eff_gnt - 4'd1)) != 4'd0;

  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (eff_gnt[i]) gnt_idx = 2'(i);
    end
  end

  assign own_gnt = m.gnt[owner_q];
  assign own_vld = m.vld[owner_q];
  assign own_dat = m.dat[owner_q];
  assign beat_ok = own_vld & m.bus_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      cnt_q   <= 4'd0;
      tmo_q   <= 8'd0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    hold_d     = 1'b0;
    rdy_o      = 4'b0000;
    bus_dat_o  = 8'h00;
    bus_vld_o  = 1'b0;
    bus_last_o = 1'b0;
    done_o     = 4'b0000;
    abort_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (multi_gnt) begin
          state_d = S_ERR;
        end else if (eff_gnt != 4'd0) begin
          owner_d = gnt_idx;
          cnt_d   = m.len[gnt_idx];
          tmo_d   = 8'd0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        bus_dat_o = own_dat;
        if (!own_gnt) begin
          // Grant loss beats everything; no beat taken.
          abort_o = 1'b1;
          hold_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          bus_vld_o      = own_vld;
          rdy_o[owner_q] = m.bus_ready;
          bus_last_o     = (cnt_q == 4'd0);
          if (beat_ok) begin
            tmo_d = 8'd0;
            if (cnt_q == 4'd0) state_d = S_DONE;
            else cnt_d = cnt_q - 4'd1;
          end else if (tmo_q >= TMO_MAX) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        done_o[owner_q] = 1'b1;
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (m.err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m.rdy       = rdy_o;
  assign m.bus_dat   = bus_dat_o;
  assign m.bus_vld   = bus_vld_o;
  assign m.bus_last  = bus_last_o;
  assign m.bus_owner = owner_q;
  assign m.done      = done_o;
  assign m.abort     = abort_o;
  assign m.err       = (state_q == S_ERR);
  assign m.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_grant_bus_mux.sv
// Scoreboard bench for grant_bus_mux.
// Beats are queued as {owner,last,dat} and popped on acceptance.
module tb_grant_bus_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;

  grant_bus_mux_if bif();

  grant_bus_mux #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .m   (bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;
  int done_cnt[4];
  int abort_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (bif.done[i]) done_cnt[i]++;
      if (bif.abort) abort_cnt++;
      if (bif.bus_vld && bif.bus_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_dat", bif.bus_dat, mon_e[7:0]);
          chk("beat_last", bif.bus_last, mon_e[8]);
          chk("beat_owner", bif.bus_owner, mon_e[10:9]);
          chk("beat_rdy", bif.rdy,
              32'(4'b0001 << mon_e[10:9]));
        end
      end
    end
  end

  task automatic push_beats(input int c, input int n,
                            input int len,
                            input logic [7:0] d);
    logic [1:0] o;
    o = 2'(c);
    for (int i = 0; i < n; i++)
      exp_q.push_back({o, i == len, d});
  endtask

  task automatic run_burst(input int c, input int len,
                           input logic [7:0] d,
                           input int stall_at,
                           input int stall_n);
    int t;
    bit seen;
    int d0;
    t = 0;
    seen = 0;
    @(posedge clk); #1;
    d0 = done_cnt[c];
    bif.len[c] = 4'(len);
    bif.dat[c] = d;
    bif.vld[c] = 1'b1;
    bif.gnt[c] = 1'b1;
    bif.bus_ready = 1'b1;
    push_beats(c, len + 1, len, d);
    while (!seen && t < 300) begin
      @(negedge clk);
      if (bif.done[c]) seen = 1;
      @(posedge clk); #1;
      t++;
      bif.bus_ready = !(t >= stall_at && t < stall_at + stall_n);
    end
    bif.gnt[c] = 1'b0;
    bif.vld[c] = 1'b0;
    bif.bus_ready = 1'b1;
    @(negedge clk);
    chk("burst_done_seen", 32'(seen), 1);
    chk("burst_done_once", done_cnt[c] - d0, 1);
    chk("burst_err", bif.err, 0);
    chk("burst_q_empty", exp_q.size(), 0);
    chk("burst_idle", bif.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nb;
    int t;
    int d0;
    int a0;
    bif.gnt = '0;
    bif.len = '0;
    bif.dat = '0;
    bif.vld = '0;
    bif.bus_ready = 1'b1;
    bif.err_clr = 1'b0;
    #2;
    chk("rst_busy", bif.busy, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_owner", bif.bus_owner, 0);
    chk("rst_vld", bif.bus_vld, 0);
    chk("rst_rdy", bif.rdy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_abort", bif.abort, 0);
    chk("rst_dat", bif.bus_dat, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic 4-beat burst from client 1
    run_burst(1, 3, 8'hA5, 0, 0);

    // ready stalls for 3 cycles mid-burst
    run_burst(2, 7, 8'h5C, 3, 3);

    // err_clr outside ERR is inert
    @(posedge clk); #1;
    bif.err_clr = 1'b1;
    @(posedge clk); #1;
    bif.err_clr = 1'b0;
    @(negedge clk);
    chk("clr_idle_err", bif.err, 0);
    chk("clr_idle_busy", bif.busy, 0);

    // timeout: vld2 held low in XFER
    @(posedge clk); #1;
    bif.len[2] = 4'd3;
    bif.vld[2] = 1'b0;
    bif.gnt[2] = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("tmo_before_err", bif.err, 0);
    chk("tmo_before_busy", bif.busy, 1);
    @(negedge clk);
    chk("tmo_err", bif.err, 1);
    chk("tmo_err_vld", bif.bus_vld, 0);
    chk("tmo_err_rdy", bif.rdy, 0);
    bif.gnt[2] = 1'b0;
    @(negedge clk);
    chk("tmo_err_sticky", bif.err, 1);
    @(posedge clk); #1;
    bif.err_clr = 1'b1;
    @(posedge clk); #1;
    bif.err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_clr_err", bif.err, 0);
    chk("tmo_clr_busy", bif.busy, 0);

    // abort after 2 of 8 beats, holdoff vs gnt3
    d0 = done_cnt[0];
    a0 = abort_cnt;
    @(posedge clk); #1;
    bif.len[0] = 4'd7;
    bif.dat[0] = 8'h3C;
    bif.vld[0] = 1'b1;
    bif.gnt[0] = 1'b1;
    push_beats(0, 2, 7, 8'h3C);
    nb = 0;
    t = 0;
    while (nb < 2 && t < 50) begin
      @(negedge clk);
      if (bif.bus_vld && bif.bus_ready) nb++;
      t++;
    end
    chk("abort_two_beats", nb, 2);
    @(posedge clk); #1;
    bif.gnt[0] = 1'b0;
    @(negedge clk);
    chk("abort_pulse", bif.abort, 1);
    chk("abort_no_vld", bif.bus_vld, 0);
    chk("abort_no_rdy", bif.rdy, 0);
    @(posedge clk); #1;
    bif.gnt[0] = 1'b1;
    bif.gnt[3] = 1'b1;
    bif.len[3] = 4'd1;
    bif.dat[3] = 8'h96;
    bif.vld[3] = 1'b1;
    push_beats(3, 2, 1, 8'h96);
    @(negedge clk);
    chk("abort_one_cycle", bif.abort, 0);
    chk("hold_idle", bif.busy, 0);
    @(posedge clk); #1;
    bif.gnt[0] = 1'b0;
    bif.vld[0] = 1'b0;
    @(negedge clk);
    chk("hold_owner3", bif.bus_owner, 3);
    chk("hold_busy", bif.busy, 1);
    t = 0;
    while (!bif.done[3] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("g3_done", bif.done[3], 1);
    @(posedge clk); #1;
    bif.gnt[3] = 1'b0;
    bif.vld[3] = 1'b0;
    @(negedge clk);
    chk("abort_no_done0", done_cnt[0] - d0, 0);
    chk("abort_count", abort_cnt - a0, 1);
    chk("abort_q_empty", exp_q.size(), 0);

    // two grants at once
    @(posedge clk); #1;
    bif.gnt[1] = 1'b1;
    bif.gnt[2] = 1'b1;
    @(posedge clk); #1;
    bif.gnt[1] = 1'b0;
    bif.gnt[2] = 1'b0;
    @(negedge clk);
    chk("multi_err", bif.err, 1);
    chk("multi_vld", bif.bus_vld, 0);
    @(posedge clk); #1;
    bif.err_clr = 1'b1;
    @(posedge clk); #1;
    bif.err_clr = 1'b0;
    @(negedge clk);
    chk("multi_clr", bif.err, 0);

    // reset in the middle of a burst
    d0 = done_cnt[1];
    a0 = abort_cnt;
    @(posedge clk); #1;
    bif.len[1] = 4'd15;
    bif.dat[1] = 8'h5A;
    bif.vld[1] = 1'b1;
    bif.gnt[1] = 1'b1;
    push_beats(1, 16, 15, 8'h5A);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bif.busy, 0);
    chk("mid_rst_vld", bif.bus_vld, 0);
    chk("mid_rst_last", bif.bus_last, 0);
    chk("mid_rst_rdy", bif.rdy, 0);
    chk("mid_rst_owner", bif.bus_owner, 0);
    chk("mid_rst_done", bif.done, 0);
    chk("mid_rst_abort", bif.abort, 0);
    exp_q.delete();
    bif.gnt[1] = 1'b0;
    bif.vld[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt[1] - d0, 0);
    chk("mid_rst_no_abort", abort_cnt - a0, 0);

    // resumes cleanly after reset
    run_burst(1, 1, 8'h77, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
